// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and 8-bit duty cycle of an external PWM input.
// Results come from an 8-step restoring divider and are flagged by a one-cycle valid strobe.
module pwm_capture #(
    parameter int WIDTH = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             en,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic [7:0]       duty_cycle,
    output logic             valid,
    output logic             stuck,
    output logic             overrun
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS, DIV} state_t;

    localparam logic [WIDTH-1:0] MAX = '1;

    state_t           state, state_nx;
    logic             s1, s2, s3;
    logic [WIDTH-1:0] cnt, hi_snap, per_snap, hi_div;
    logic [WIDTH:0]   r, r_sh, r_nx;
    logic [7:0]       q, q_nx;
    logic [2:0]       it;
    logic             rise, fall, tmo, start, done, ge;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // r stays below per_snap, so the shifted remainder always fits in WIDTH+1 bits
    assign r_sh = {r[WIDTH-1:0], 1'b0};
    assign ge   = r_sh >= {1'b0, per_snap};
    assign r_nx = ge ? r_sh - {1'b0, per_snap} : r_sh;
    assign q_nx = {q[6:0], ge};

    always_comb begin
        state_nx = state;
        tmo      = 1'b0;
        start    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: state_nx = ARM;
            ARM: begin
                tmo      = ~rise & (cnt == MAX);
                state_nx = rise ? MEAS : ARM;
            end
            MEAS: begin
                tmo      = ~rise & (cnt == MAX);
                start    = rise;
                state_nx = rise ? DIV : (tmo ? ARM : MEAS);
            end
            DIV: begin
                done     = it == 3'd7;
                state_nx = done ? MEAS : DIV;
            end
        endcase
        if (!en) begin
            state_nx = IDLE;
            tmo      = 1'b0;
            start    = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            {s3, s2, s1} <= '0;
            cnt          <= '0;
            hi_snap      <= '0;
            per_snap     <= '0;
            hi_div       <= '0;
            r            <= '0;
            q            <= '0;
            it           <= '0;
            period       <= '0;
            high_time    <= '0;
            duty_cycle   <= '0;
            valid        <= 1'b0;
            stuck        <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            {s3, s2, s1} <= {s2, s1, pwm_in};
            valid        <= tmo | done;
            overrun      <= en & (overrun | ((state == DIV) & rise));
            // a timeout restarts the count so a held level re-reports every MAX cycles
            if (!en || state == IDLE)
                cnt <= '0;
            else if (rise || tmo)
                cnt <= WIDTH'(1);
            else if (cnt != MAX)
                cnt <= cnt + WIDTH'(1);
            if (fall)
                hi_snap <= cnt;
            if (start) begin
                per_snap <= cnt;
                hi_div   <= hi_snap;
                r        <= {1'b0, hi_snap};
                it       <= '0;
            end
            if (state == DIV) begin
                r  <= r_nx;
                q  <= q_nx;
                it <= it + 3'd1;
            end
            if (done) begin
                period     <= per_snap;
                high_time  <= hi_div;
                duty_cycle <= q_nx;
                stuck      <= 1'b0;
            end
            if (tmo) begin
                period     <= MAX;
                high_time  <= MAX;
                duty_cycle <= {8{s2}};
                stuck      <= 1'b1;
            end
        end
    end
endmodule
